// File: rtl/master_gen_pkg.sv
// master_gen_pkg: state encoding and Galois LFSR tap masks.
// These are shared by master_gen and master_gen_lfsr.
package master_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        REQ,
        RELEASE,
        DONE
    } state_t;

    // Right-shift Galois masks, maximal length for each width
    localparam logic [63:0] LFSR_TAPS_4  = 64'h0000_0000_0000_000C;
    localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            4:       return LFSR_TAPS_4;
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            32:      return LFSR_TAPS_32;
            64:      return LFSR_TAPS_64;
            default: return 64'd1 << (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/master_gen_lfsr.sv
// master_gen_lfsr: one combinational right-shift Galois LFSR step over DATA_W bits.
// Used by master_gen only when MASTER_GEN_LFSR_EN is defined.
module master_gen_lfsr
    import master_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt
);

    localparam logic [63:0]       TAPS = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] MASK = TAPS[DATA_W-1:0];

    always_comb nxt = (cur >> 1) ^ (cur[0] ? MASK : '0);

endmodule

// File: rtl/master_gen.sv
// master_gen: req/ack data master with programmable gap, transaction limit and counter.
// Define MASTER_GEN_LFSR_EN to replace the incrementing payload with a Galois LFSR.
//
//   state   | meaning
//   IDLE    | stopped, waiting for en
//   GAP     | counting idle cycles before the next request
//   REQ     | req high, waiting for ack
//   RELEASE | four-phase only: waiting for ack to fall
//   DONE    | transaction limit reached, waiting for en low
module master_gen
    import master_gen_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                GAP_W      = 8,
    parameter int                CNT_W      = 16,
    parameter bit                FOUR_PHASE = 1'b0,
    parameter logic [DATA_W-1:0] SEED       = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [GAP_W-1:0]  gap,
    input  logic [CNT_W-1:0]  num_txn,
    output logic              req,
    output logic [DATA_W-1:0] data,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  txn_cnt
);

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
    logic [DATA_W-1:0] data_q, data_d, data_next;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef MASTER_GEN_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    localparam logic [DATA_W-1:0] SEED_RST = (SEED == '0) ? DATA_W'(1) : SEED;

    master_gen_lfsr #(.DATA_W(DATA_W)) u_lfsr (
        .cur (data_q),
        .nxt (data_next)
    );
`else
    localparam logic [DATA_W-1:0] SEED_RST = SEED;

    assign data_next = data_q + DATA_W'(1);
`endif

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        num_d     = num_q;
        txn_cnt_d = txn_cnt_q;
        data_d    = data_q;
        req_d     = req_q;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (en) begin
                    state_d   = GAP;
                    gap_cnt_d = gap;
                    num_d     = num_txn;
                end
            end
            GAP: begin
                req_d = 1'b0;
                if (!en) begin
                    state_d = IDLE;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    data_d  = data_next;
                end
            end
            REQ: begin
                if (ack) begin
                    req_d     = 1'b0;
                    txn_cnt_d = txn_cnt_q + CNT_W'(1);
                    if (FOUR_PHASE) begin
                        state_d = RELEASE;
                    end else if ((num_q != '0) && (txn_cnt_d == num_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap;
                    end
                end
            end
            RELEASE: begin
                if (!ack) begin
                    if ((num_q != '0) && (txn_cnt_q == num_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap;
                    end
                end
            end
            DONE: begin
                req_d = 1'b0;
                if (!en) begin
                    state_d   = IDLE;
                    txn_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d == GAP) || (state_d == REQ) || (state_d == RELEASE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            num_q     <= '0;
            txn_cnt_q <= '0;
            data_q    <= SEED_RST;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            num_q     <= num_d;
            txn_cnt_q <= txn_cnt_d;
            data_q    <= data_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign req     = req_q;
    assign data    = data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_master_gen.sv
// tb_master_gen: scoreboard bench for master_gen in two-phase, four-phase and narrow-width builds.
// With MASTER_GEN_LFSR_EN defined the narrow instance is 8 bits wide and the LFSR period is checked.
`timescale 1ns/1ps
module tb_master_gen;

    localparam int DW = 32;
`ifdef MASTER_GEN_LFSR_EN
    localparam int            WW     = 8;
    localparam logic [WW-1:0] W_SEED = 8'd0;
`else
    localparam int            WW     = 4;
    localparam logic [WW-1:0] W_SEED = 4'd14;
`endif
    localparam logic [DW-1:0] SEED_A = 32'd0;
    localparam logic [DW-1:0] SEED_B = 32'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic          en_a = 1'b0, ack_a = 1'b0;
    logic [7:0]    gap_a = 8'd0;
    logic [15:0]   num_a = 16'd0;
    logic          req_a, busy_a, done_a;
    logic [DW-1:0] data_a;
    logic [15:0]   cnt_a;

    logic          en_b = 1'b0, ack_b = 1'b0;
    logic [7:0]    gap_b = 8'd0;
    logic [15:0]   num_b = 16'd0;
    logic          req_b, busy_b, done_b;
    logic [DW-1:0] data_b;
    logic [15:0]   cnt_b;

    logic          en_w = 1'b0, ack_w = 1'b0;
    logic [7:0]    gap_w = 8'd0;
    logic [15:0]   num_w = 16'd0;
    logic          req_w, busy_w, done_w;
    logic [WW-1:0] data_w;
    logic [15:0]   cnt_w;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_a, exp_b;
    logic [WW-1:0] exp_w;
    logic [DW-1:0] q32[$];
    logic [WW-1:0] qw[$];

    always #5 clk = ~clk;

    master_gen #(.DATA_W(DW), .GAP_W(8), .CNT_W(16), .FOUR_PHASE(1'b0), .SEED(SEED_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .gap(gap_a), .num_txn(num_a),
        .req(req_a), .data(data_a), .ack(ack_a), .busy(busy_a), .done(done_a), .txn_cnt(cnt_a)
    );

    master_gen #(.DATA_W(DW), .GAP_W(8), .CNT_W(16), .FOUR_PHASE(1'b1), .SEED(SEED_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .gap(gap_b), .num_txn(num_b),
        .req(req_b), .data(data_b), .ack(ack_b), .busy(busy_b), .done(done_b), .txn_cnt(cnt_b)
    );

    master_gen #(.DATA_W(WW), .GAP_W(8), .CNT_W(16), .FOUR_PHASE(1'b0), .SEED(W_SEED)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en_w), .gap(gap_w), .num_txn(num_w),
        .req(req_w), .data(data_w), .ack(ack_w), .busy(busy_w), .done(done_w), .txn_cnt(cnt_w)
    );

    // Reference payload sequence, written independently of the RTL
    function automatic logic [DW-1:0] nxt32(input logic [DW-1:0] x);
`ifdef MASTER_GEN_LFSR_EN
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
`else
        return x + 32'd1;
`endif
    endfunction

    function automatic logic [WW-1:0] nxtw(input logic [WW-1:0] x);
`ifdef MASTER_GEN_LFSR_EN
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
`else
        return x + 4'd1;
`endif
    endfunction

    function automatic logic [DW-1:0] seed32(input logic [DW-1:0] s);
`ifdef MASTER_GEN_LFSR_EN
        return (s == 32'd0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [WW-1:0] seedw(input logic [WW-1:0] s);
`ifdef MASTER_GEN_LFSR_EN
        return (s == 8'd0) ? 8'd1 : s;
`else
        return s;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        en_a = 1'b0; en_b = 1'b0; en_w = 1'b0;
        ack_a = 1'b0; ack_b = 1'b0; ack_w = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = seed32(SEED_A);
        exp_b = seed32(SEED_B);
        exp_w = seedw(W_SEED);
        q32.delete();
        qw.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b busy=%b done=%b, expected 0 0 0", req_a, busy_a, done_a);
        end
        checks++;
        if (data_a !== seed32(SEED_A)) begin
            errors++;
            $display("FAIL reset_data_a: got %0h, expected %0h", data_a, seed32(SEED_A));
        end
        checks++;
        if (cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d, expected 0", cnt_a);
        end
        checks++;
        if (data_b !== seed32(SEED_B) || data_w !== seedw(W_SEED)) begin
            errors++;
            $display("FAIL reset_data_bw: got %0h/%0h, expected %0h/%0h", data_b, data_w, seed32(SEED_B), seedw(W_SEED));
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = seed32(SEED_A);
        exp_b = seed32(SEED_B);
        exp_w = seedw(W_SEED);
    endtask

    task automatic test_two_phase();
        int rises = 0, low = 0, cyc = 0;
        logic prev = 1'b0;
        logic [DW-1:0] e;
        do_reset();
        gap_a = 8'd0;
        num_a = 16'd0;
        for (int i = 0; i < 4; i++) begin
            exp_a = nxt32(exp_a);
            q32.push_back(exp_a);
        end
        en_a = 1'b1;
        while (rises < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req_a && !prev) begin
                rises++;
                e = (q32.size() != 0) ? q32.pop_front() : 'x;
                checks++;
                if (data_a !== e) begin
                    errors++;
                    $display("FAIL two_phase_data #%0d: got %0h, expected %0h", rises, data_a, e);
                end
                if (rises > 1) begin
                    checks++;
                    if (low !== 1) begin
                        errors++;
                        $display("FAIL two_phase_gap #%0d: req low %0d cycles, expected 1", rises, low);
                    end
                    checks++;
                    if (cnt_a !== 16'(rises - 1)) begin
                        errors++;
                        $display("FAIL two_phase_cnt #%0d: got %0d, expected %0d", rises, cnt_a, rises - 1);
                    end
                end
                low = 0;
            end else if (!req_a) begin
                low++;
            end
            ack_a = req_a;
            prev = req_a;
        end
        checks++;
        if (rises != 4) begin
            errors++;
            $display("FAIL two_phase_timeout: got %0d requests, expected 4", rises);
        end
        @(negedge clk);
        ack_a = 1'b0;
        en_a = 1'b0;
        checks++;
        if (cnt_a !== 16'd4 || req_a !== 1'b0) begin
            errors++;
            $display("FAIL two_phase_final: cnt=%0d req=%b, expected 4 0", cnt_a, req_a);
        end
    endtask

    task automatic test_gap_limit();
        int rises = 0, low = 0, cyc = 0;
        logic prev = 1'b0, saw_req = 1'b0;
        logic [DW-1:0] e;
        do_reset();
        gap_a = 8'd3;
        num_a = 16'd5;
        for (int i = 0; i < 5; i++) begin
            exp_a = nxt32(exp_a);
            q32.push_back(exp_a);
        end
        en_a = 1'b1;
        while (!done_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req_a && !prev) begin
                rises++;
                e = (q32.size() != 0) ? q32.pop_front() : 'x;
                checks++;
                if (data_a !== e) begin
                    errors++;
                    $display("FAIL gap_limit_data #%0d: got %0h, expected %0h", rises, data_a, e);
                end
                if (rises > 1) begin
                    checks++;
                    if (low !== 4) begin
                        errors++;
                        $display("FAIL gap_limit_gap #%0d: req low %0d cycles, expected 4", rises, low);
                    end
                end
                low = 0;
            end else if (!req_a) begin
                low++;
            end
            ack_a = req_a;
            prev = req_a;
        end
        ack_a = 1'b0;
        checks++;
        if (rises != 5 || done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 16'd5) begin
            errors++;
            $display("FAIL gap_limit_done: reqs=%0d done=%b busy=%b cnt=%0d, expected 5 1 0 5", rises, done_a, busy_a, cnt_a);
        end
        repeat (6) begin
            @(negedge clk);
            saw_req |= req_a;
        end
        checks++;
        if (saw_req !== 1'b0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL gap_limit_hold: saw_req=%b done=%b, expected 0 1", saw_req, done_a);
        end
        en_a = 1'b0;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL gap_limit_clear: done=%b cnt=%0d, expected 0 0", done_a, cnt_a);
        end
    endtask

    task automatic test_four_phase();
        int rises = 0, low = 0, cyc = 0, hi = 0, age = 0;
        logic prev = 1'b0;
        logic [DW-1:0] e, held;
        held = '0;
        do_reset();
        gap_b = 8'd2;
        num_b = 16'd3;
        for (int i = 0; i < 3; i++) begin
            exp_b = nxt32(exp_b);
            q32.push_back(exp_b);
        end
        en_b = 1'b1;
        while (!done_b && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack_b) begin
                hi++;
                if (hi == 1) begin
                    checks++;
                    if (req_b !== 1'b0) begin
                        errors++;
                        $display("FAIL four_req_drop #%0d: req=%b one cycle after ack, expected 0", rises, req_b);
                    end
                end
                if (hi == 3) begin
                    checks++;
                    if (busy_b !== 1'b1 || req_b !== 1'b0) begin
                        errors++;
                        $display("FAIL four_release: busy=%b req=%b, expected 1 0", busy_b, req_b);
                    end
                end
                if (hi == 6) begin
                    ack_b = 1'b0;
                    low = 0;
                end
            end else begin
                if (req_b && !prev) begin
                    rises++;
                    e = (q32.size() != 0) ? q32.pop_front() : 'x;
                    checks++;
                    if (data_b !== e) begin
                        errors++;
                        $display("FAIL four_data #%0d: got %0h, expected %0h", rises, data_b, e);
                    end
                    if (rises > 1) begin
                        checks++;
                        if (low !== 3) begin
                            errors++;
                            $display("FAIL four_gap #%0d: req low %0d cycles after ack fall, expected 3", rises, low);
                        end
                    end
                    held = data_b;
                    age = 0;
                end else if (req_b) begin
                    checks++;
                    if (data_b !== held) begin
                        errors++;
                        $display("FAIL four_stable: data %0h changed from %0h while req=1", data_b, held);
                    end
                end else begin
                    low++;
                end
                if (req_b) begin
                    age++;
                    if (age == 3) begin
                        ack_b = 1'b1;
                        hi = 0;
                    end
                end
            end
            prev = req_b;
        end
        checks++;
        if (rises != 3 || done_b !== 1'b1 || cnt_b !== 16'd3 || req_b !== 1'b0) begin
            errors++;
            $display("FAIL four_done: reqs=%0d done=%b cnt=%0d req=%b, expected 3 1 3 0", rises, done_b, cnt_b, req_b);
        end
        en_b = 1'b0;
        @(negedge clk);
        checks++;
        if (done_b !== 1'b0 || cnt_b !== 16'd0) begin
            errors++;
            $display("FAIL four_clear: done=%b cnt=%0d, expected 0 0", done_b, cnt_b);
        end
    endtask

    task automatic test_enable();
        int cyc = 0;
        logic saw_req = 1'b0, moved = 1'b0;
        logic [DW-1:0] e;
        do_reset();
        gap_a = 8'd5;
        num_a = 16'd0;
        en_a = 1'b1;
        repeat (3) @(negedge clk);
        en_a = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw_req |= req_a;
        end
        checks++;
        if (saw_req !== 1'b0 || busy_a !== 1'b0 || data_a !== exp_a) begin
            errors++;
            $display("FAIL enable_gap_abort: saw_req=%b busy=%b data=%0h, expected 0 0 %0h", saw_req, busy_a, data_a, exp_a);
        end
        gap_a = 8'd0;
        exp_a = nxt32(exp_a);
        q32.push_back(exp_a);
        en_a = 1'b1;
        while (!req_a && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        e = (q32.size() != 0) ? q32.pop_front() : 'x;
        checks++;
        if (req_a !== 1'b1 || data_a !== e) begin
            errors++;
            $display("FAIL enable_req: req=%b data=%0h, expected 1 %0h", req_a, data_a, e);
        end
        en_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (req_a !== 1'b1 || data_a !== e) moved = 1'b1;
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL enable_req_held: req=%b data=%0h, expected req held at 1 with %0h", req_a, data_a, e);
        end
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        checks++;
        if (req_a !== 1'b0 || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL enable_ack: req=%b cnt=%0d, expected 0 1", req_a, cnt_a);
        end
        saw_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_req |= req_a;
        end
        checks++;
        if (saw_req !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL enable_stop: saw_req=%b busy=%b, expected 0 0", saw_req, busy_a);
        end
    endtask

`ifdef MASTER_GEN_LFSR_EN
    task automatic test_lfsr();
        int rises = 0, cyc = 0, distinct = 0;
        logic prev = 1'b0, bad = 1'b0;
        logic [WW-1:0] e, first;
        bit seen [256];
        first = '0;
        do_reset();
        checks++;
        if (data_w !== 8'd1) begin
            errors++;
            $display("FAIL lfsr_seed: got %0h, expected 1", data_w);
        end
        for (int i = 0; i < 256; i++) begin
            exp_w = nxtw(exp_w);
            qw.push_back(exp_w);
        end
        gap_w = 8'd0;
        num_w = 16'd0;
        en_w = 1'b1;
        while (rises < 256 && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (req_w && !prev) begin
                rises++;
                e = (qw.size() != 0) ? qw.pop_front() : 'x;
                if (data_w !== e) bad = 1'b1;
                if (rises == 1) first = data_w;
                if (rises <= 255) begin
                    if (data_w == 8'd0 || seen[data_w]) bad = 1'b1;
                    else distinct++;
                    seen[data_w] = 1'b1;
                end
            end
            ack_w = req_w;
            prev = req_w;
        end
        ack_w = 1'b0;
        en_w = 1'b0;
        checks++;
        if (first !== 8'hB8) begin
            errors++;
            $display("FAIL lfsr_first: got %0h, expected b8", first);
        end
        checks++;
        if (bad !== 1'b0 || distinct != 255) begin
            errors++;
            $display("FAIL lfsr_period: distinct=%0d bad=%b, expected 255 0", distinct, bad);
        end
        checks++;
        if (rises != 256 || data_w !== first) begin
            errors++;
            $display("FAIL lfsr_repeat: reqs=%0d data=%0h, expected 256 %0h", rises, data_w, first);
        end
    endtask
`else
    task automatic test_wrap();
        int rises = 0, cyc = 0;
        logic prev = 1'b0;
        logic [WW-1:0] e;
        do_reset();
        checks++;
        if (data_w !== 4'd14) begin
            errors++;
            $display("FAIL wrap_seed: got %0d, expected 14", data_w);
        end
        for (int i = 0; i < 2; i++) begin
            exp_w = nxtw(exp_w);
            qw.push_back(exp_w);
        end
        gap_w = 8'd0;
        num_w = 16'd0;
        en_w = 1'b1;
        while (rises < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (req_w && !prev) begin
                rises++;
                e = (qw.size() != 0) ? qw.pop_front() : 'x;
                checks++;
                if (data_w !== e) begin
                    errors++;
                    $display("FAIL wrap_data #%0d: got %0d, expected %0d", rises, data_w, e);
                end
            end
            ack_w = req_w;
            prev = req_w;
        end
        ack_w = 1'b0;
        en_w = 1'b0;
        checks++;
        if (rises != 2) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d requests, expected 2", rises);
        end
    endtask
`endif

    task automatic test_reset_mid_req();
        int rises = 0, cyc = 0;
        logic prev = 1'b0;
        logic [DW-1:0] e;
        do_reset();
        e = exp_a;
        repeat (7) e = nxt32(e);
        gap_a = 8'd0;
        num_a = 16'd0;
        en_a = 1'b1;
        while (rises < 7 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req_a && !prev) rises++;
            prev = req_a;
            ack_a = req_a && (rises < 7);
        end
        checks++;
        if (req_a !== 1'b1 || data_a !== e) begin
            errors++;
            $display("FAIL midreq_setup: req=%b data=%0h, expected 1 %0h", req_a, data_a, e);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midreq_ctrl: req=%b done=%b busy=%b, expected 0 0 0", req_a, done_a, busy_a);
        end
        checks++;
        if (data_a !== seed32(SEED_A)) begin
            errors++;
            $display("FAIL midreq_data: got %0h, expected %0h", data_a, seed32(SEED_A));
        end
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_phase();
        test_gap_limit();
        test_four_phase();
        test_enable();
`ifdef MASTER_GEN_LFSR_EN
        test_lfsr();
`else
        test_wrap();
`endif
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
